net_activity_monitor: RTL

NET_ACTIVITY_MONITOR -- requirements
Module: net_activity_monitor

---
 rtl/net_activity_monitor.sv | 108 ++++++++++
 1 files changed

// File: rtl/net_activity_monitor.sv
// Net activity monitor: counts toggles and high cycles of one net over a
// 2^WIN_W-cycle window and reports rare/stuck activity against a threshold.
//
// state  | meaning
// IDLE   | waiting for start; results held
// ARM    | one cycle, samples the net into prev, counts nothing
// COUNT  | 2^WIN_W cycles of toggle / ones accumulation
// REPORT | one cycle, done pulse; results loaded on entry
module net_activity_monitor #(
  parameter int WIN_W = 8,
  parameter int CNT_W = WIN_W + 1
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             I10035,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             rare,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state;
  logic             prev;
  logic [CNT_W-1:0] tog_acc;
  logic [CNT_W-1:0] ones_acc;
  logic [CNT_W-1:0] thresh_q;
  logic [WIN_W-1:0] cyc;

  logic [CNT_W-1:0] tog_nxt;
  logic [CNT_W-1:0] ones_nxt;
  logic             last_cyc;

  // Accumulator values including the current sample, so the exit edge can
  // load results directly without an extra pipeline cycle.
  assign tog_nxt  = tog_acc + CNT_W'(I10035 ^ prev);
  assign ones_nxt = ones_acc + CNT_W'(I10035);
  assign last_cyc = (cyc == {WIN_W{1'b1}});

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      toggle_cnt <= '0;
      ones_cnt   <= '0;
      rare       <= 1'b0;
      stuck      <= 1'b0;
      prev       <= 1'b0;
      tog_acc    <= '0;
      ones_acc   <= '0;
      thresh_q   <= '0;
      cyc        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            thresh_q <= thresh;
            tog_acc  <= '0;
            ones_acc <= '0;
            cyc      <= '0;
          end
        end
        ARM: begin
          prev  <= I10035;
          state <= COUNT;
        end
        COUNT: begin
          prev     <= I10035;
          tog_acc  <= tog_nxt;
          ones_acc <= ones_nxt;
          cyc      <= cyc + 1'b1;
          if (last_cyc) begin
            state      <= REPORT;
            done       <= 1'b1;
            toggle_cnt <= tog_nxt;
            ones_cnt   <= ones_nxt;
            // thresh_q == 0 can never exceed an unsigned count, so rare stays 0
            rare       <= (tog_nxt < thresh_q);
            stuck      <= (tog_nxt == '0);
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
